// File: rtl/hazard_sched_ctrl.sv
// Pipeline sequencing controller: run / load-use stall / branch flush / memory freeze.
// Ports: clk_i, start_i (async active-low), ID/EX hazard inputs, mem handshake, enables, counters, timeout flag.
module hazard_sched_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs2_i,
  input  logic             id_branch_i,
  input  logic             id_taken_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o,
  output logic             err_timeout_o
);

  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(MEM_TIMEOUT);

  state_t        state;
  logic [TW-1:0] timer;

  logic rd_nz;
  logic dep;
  logic lu;
  logic bop;
  logic stall;
  logic flush;
  logic frz;
  logic do_stall;
  logic do_flush;

  // x0 is never a producer, so rd==0 masks every match
  assign rd_nz = (ex_rd_i != 5'd0);
  assign dep   = rd_nz & ((ex_rd_i == id_rs1_i) |
                 (id_use_rs2_i & (ex_rd_i == id_rs2_i)));

  assign lu    = ex_memread_i & dep;
  assign bop   = id_branch_i & ex_regwrite_i &
                 ~ex_memread_i & dep;
  assign stall = lu | bop;
  assign flush = id_branch_i & id_taken_i & ~stall;

  // ready in MEMWAIT is the completion cycle, not a freeze
  assign frz      = ((state == MEMWAIT) | mem_req_i) &
                    ~mem_ready_i;
  assign do_stall = stall & ~frz;
  assign do_flush = flush & ~frz;

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    if (start_i) begin
      unique case (1'b1)
        frz: begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          freeze_o     = 1'b1;
        end
        do_stall: begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
        end
        do_flush: begin
          ifid_flush_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state         <= RUN;
      timer         <= '0;
      err_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      wait_cnt_o    <= '0;
    end else begin
      state <= frz ? MEMWAIT : RUN;

      if (frz) begin
        if (timer == TO_LAST)
          err_timeout_o <= 1'b1;
        if (timer != TO_MAX)
          timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      // a stalled branch is counted once, when it flushes
      if (do_stall && !id_branch_i &&
          stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (do_flush && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 1'b1;
      if (frz && wait_cnt_o != '1)
        wait_cnt_o <= wait_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Testbench for hazard_sched_ctrl: directed scenarios plus random run vs a cycle model.
// Small counter width and timeout so saturation and timeout are reachable quickly.
module tb_hazard_sched_ctrl;

  localparam int CW  = 5;
  localparam int MT  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          start_i;
  logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i;
  logic          id_use_rs2_i, id_branch_i, id_taken_i;
  logic          ex_memread_i, ex_regwrite_i;
  logic          mem_req_i, mem_ready_i;
  logic          pc_write_o, ifid_write_o, ifid_flush_o;
  logic          idex_bubble_o, freeze_o, err_timeout_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_wait;
  int m_timer;
  bit m_err;
  int m_stall, m_flush, m_wcnt;

  hazard_sched_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(MT)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs2_i(id_use_rs2_i),
    .id_branch_i(id_branch_i), .id_taken_i(id_taken_i),
    .ex_memread_i(ex_memread_i),
    .ex_regwrite_i(ex_regwrite_i), .ex_rd_i(ex_rd_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .wait_cnt_o(wait_cnt_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // 0 run, 1 flush, 2 stall, 3 freeze
  function automatic int classify();
    bit dep, lu, bop, st;
    dep = (ex_rd_i != 0) && ((ex_rd_i == id_rs1_i) ||
          (id_use_rs2_i && ex_rd_i == id_rs2_i));
    lu  = ex_memread_i && dep;
    bop = id_branch_i && ex_regwrite_i &&
          !ex_memread_i && dep;
    st  = lu || bop;
    if ((m_wait || mem_req_i) && !mem_ready_i) return 3;
    if (st) return 2;
    if (id_branch_i && id_taken_i) return 1;
    return 0;
  endfunction

  // {pc_write, ifid_write, ifid_flush, bubble, freeze}
  function automatic logic [4:0] predict();
    if (!start_i) return 5'b11000;
    case (classify())
      3: return 5'b00001;
      2: return 5'b00010;
      1: return 5'b11100;
      default: return 5'b11000;
    endcase
  endfunction

  function automatic logic [4:0] obs();
    return {pc_write_o, ifid_write_o, ifid_flush_o,
            idex_bubble_o, freeze_o};
  endfunction

  task automatic tick();
    int c;
    c = classify();
    @(posedge clk_i);
    if (!start_i) begin
      m_wait = 0; m_timer = 0; m_err = 0;
      m_stall = 0; m_flush = 0; m_wcnt = 0;
    end else begin
      m_wait = (c == 3);
      if (c == 3) begin
        m_timer++;
        if (m_timer >= MT) m_err = 1;
        if (m_wcnt < MAX) m_wcnt++;
      end else begin
        m_timer = 0;
      end
      if (c == 2 && !id_branch_i && m_stall < MAX)
        m_stall++;
      if (c == 1 && m_flush < MAX) m_flush++;
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
    id_use_rs2_i = 0; id_branch_i = 0; id_taken_i = 0;
    ex_memread_i = 0; ex_regwrite_i = 0;
    mem_req_i = 0; mem_ready_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    start_i = 0;
    tick();
    start_i = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    start_i = 0;
    mem_req_i = 1;
    #2;
    checks++;
    if (obs() !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outs got %b want 11000", obs());
    end
    tick();
    checks++;
    if (stall_cnt_o !== 0 || flush_cnt_o !== 0 ||
        wait_cnt_o !== 0 || err_timeout_o !== 0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d/%0d/%b want 0",
               stall_cnt_o, flush_cnt_o, wait_cnt_o,
               err_timeout_o);
    end
    start_i = 1;
    mem_req_i = 0;
    #2;
    checks++;
    if (obs() !== 5'b11000) begin
      errors++;
      $display("FAIL post_reset got %b want 11000", obs());
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread_i = 1; ex_regwrite_i = 1; ex_rd_i = 1;
    id_rs1_i = 1; id_rs2_i = 3; id_use_rs2_i = 1;
    #2;
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL lu_outs got %b want 00010", obs());
    end
    tick();
    checks++;
    if (stall_cnt_o !== 1) begin
      errors++;
      $display("FAIL lu_cnt got %0d want 1", stall_cnt_o);
    end
    clear_inputs();
    ex_regwrite_i = 1; ex_rd_i = 2; id_rs1_i = 1;
    #2;
    checks++;
    if (obs() !== 5'b11000) begin
      errors++;
      $display("FAIL lu_after got %b want 11000", obs());
    end
    tick();
    // rs2 match only counts when rs2 is read
    clear_inputs();
    ex_memread_i = 1; ex_rd_i = 5; id_rs2_i = 5;
    #2;
    checks++;
    if (obs() !== 5'b11000) begin
      errors++;
      $display("FAIL lu_nors2 got %b want 11000", obs());
    end
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    id_branch_i = 1; id_taken_i = 1;
    id_rs1_i = 4; id_rs2_i = 6; id_use_rs2_i = 1;
    ex_regwrite_i = 1; ex_rd_i = 7;
    #2;
    checks++;
    if (obs() !== 5'b11100) begin
      errors++;
      $display("FAIL flush_outs got %b want 11100", obs());
    end
    tick();
    checks++;
    if (flush_cnt_o !== 1 || stall_cnt_o !== 1) begin
      errors++;
      $display("FAIL flush_cnt got f%0d s%0d want f1 s1",
               flush_cnt_o, stall_cnt_o);
    end
    // BOP: stalled branch, not counted as a stall
    ex_rd_i = 6;
    #2;
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL bop_outs got %b want 00010", obs());
    end
    tick();
    checks++;
    if (flush_cnt_o !== 1 || stall_cnt_o !== 1) begin
      errors++;
      $display("FAIL bop_cnt got f%0d s%0d want f1 s1",
               flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_x0();
    clear_inputs();
    ex_memread_i = 1; ex_regwrite_i = 1;
    ex_rd_i = 0; id_rs1_i = 0;
    #2;
    checks++;
    if (obs() !== 5'b11000) begin
      errors++;
      $display("FAIL x0_outs got %b want 11000", obs());
    end
    tick();
    checks++;
    if (stall_cnt_o !== 1) begin
      errors++;
      $display("FAIL x0_cnt got %0d want 1", stall_cnt_o);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    ex_memread_i = 1; ex_rd_i = 9; id_rs1_i = 9;
    mem_req_i = 1; mem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (obs() !== 5'b00001) begin
        errors++;
        $display("FAIL frz_outs%0d got %b want 00001",
                 i, obs());
      end
      tick();
    end
    checks++;
    if (wait_cnt_o !== 3 || stall_cnt_o !== 0) begin
      errors++;
      $display("FAIL frz_cnt got w%0d s%0d want w3 s0",
               wait_cnt_o, stall_cnt_o);
    end
    mem_ready_i = 1;
    #2;
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL frz_done got %b want 00010", obs());
    end
    tick();
    checks++;
    if (wait_cnt_o !== 3 || stall_cnt_o !== 1 ||
        err_timeout_o !== 0) begin
      errors++;
      $display("FAIL frz_end got w%0d s%0d e%b want w3 s1 e0",
               wait_cnt_o, stall_cnt_o, err_timeout_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_i = 1; mem_ready_i = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      mem_req_i = 0;
      checks++;
      if (err_timeout_o !== (i >= MT)) begin
        errors++;
        $display("FAIL tmo_wait%0d got %b want %b",
                 i, err_timeout_o, (i >= MT));
      end
    end
    mem_ready_i = 1;
    tick();
    mem_ready_i = 0;
    checks++;
    if (err_timeout_o !== 1 || wait_cnt_o !== 6) begin
      errors++;
      $display("FAIL tmo_sticky got e%b w%0d want e1 w6",
               err_timeout_o, wait_cnt_o);
    end
    mem_req_i = 1;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (wait_cnt_o !== MAX || err_timeout_o !== 1) begin
      errors++;
      $display("FAIL wait_sat got %0d want %0d",
               wait_cnt_o, MAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      start_i       = ($urandom_range(0, 99) != 0);
      id_rs1_i      = 5'($urandom_range(0, 3));
      id_rs2_i      = 5'($urandom_range(0, 3));
      ex_rd_i       = 5'($urandom_range(0, 3));
      id_use_rs2_i  = 1'($urandom);
      id_branch_i   = ($urandom_range(0, 2) == 0);
      id_taken_i    = 1'($urandom);
      ex_memread_i  = ($urandom_range(0, 2) == 0);
      ex_regwrite_i = 1'($urandom);
      mem_req_i     = ($urandom_range(0, 3) == 0);
      mem_ready_i   = ($urandom_range(0, 4) == 0);
      #2;
      checks++;
      if (obs() !== predict()) begin
        errors++;
        $display("FAIL rnd_outs@%0d got %b want %b",
                 n, obs(), predict());
      end
      tick();
      checks++;
      if (stall_cnt_o !== CW'(m_stall) ||
          flush_cnt_o !== CW'(m_flush) ||
          wait_cnt_o !== CW'(m_wcnt) ||
          err_timeout_o !== m_err) begin
        errors++;
        $display("FAIL rnd_cnt@%0d got s%0d f%0d w%0d e%b want s%0d f%0d w%0d e%b",
                 n, stall_cnt_o, flush_cnt_o, wait_cnt_o,
                 err_timeout_o, m_stall, m_flush,
                 m_wcnt, m_err);
      end
    end
  endtask

  initial begin
    clear_inputs();
    start_i = 0;
    #12;
    test_reset();
    test_load_use();
    test_flush();
    test_x0();
    test_freeze();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
